// File: rtl/rv32i_mem_pkg.sv
// Shared RV32I data-memory definitions: funct3 encodings for loads and stores,
// load-unit FSM states, and the access-size helper.
package rv32i_mem_pkg;

  localparam logic [2:0] Funct3Lb  = 3'b000;
  localparam logic [2:0] Funct3Lh  = 3'b001;
  localparam logic [2:0] Funct3Lw  = 3'b010;
  localparam logic [2:0] Funct3Lbu = 3'b100;
  localparam logic [2:0] Funct3Lhu = 3'b101;

  localparam logic [2:0] Funct3Sb  = 3'b000;
  localparam logic [2:0] Funct3Sh  = 3'b001;
  localparam logic [2:0] Funct3Sw  = 3'b010;

  typedef enum logic [2:0] {
    StIdle,
    StReq0,
    StWait0,
    StReq1,
    StWait1,
    StDone
  } ld_state_e;

  // Bytes moved by a load; 0 marks an illegal load funct3.
  function automatic logic [2:0] access_size(input logic [2:0] funct3);
    case (funct3)
      Funct3Lb, Funct3Lbu: access_size = 3'd1;
      Funct3Lh, Funct3Lhu: access_size = 3'd2;
      Funct3Lw:            access_size = 3'd4;
      default:             access_size = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/load_extract_rv32i.sv
// Combinational byte alignment and sign/zero extension of RV32I load data
// taken from a little-endian {hi, lo} word pair.
module load_extract_rv32i
  import rv32i_mem_pkg::*;
(
  input  logic [31:0] word_hi,
  input  logic [31:0] word_lo,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] window;

  always_comb begin
    window = 32'({word_hi, word_lo} >> {offset, 3'b000});
    result = '0;
    case (funct3)
      Funct3Lb:  result = {{24{window[7]}}, window[7:0]};
      Funct3Lh:  result = {{16{window[15]}}, window[15:0]};
      Funct3Lw:  result = window;
      Funct3Lbu: result = {24'h0, window[7:0]};
      Funct3Lhu: result = {16'h0, window[15:0]};
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/dmem_load_unit_rv32i.sv
// RV32I load unit in front of a synchronous-read data RAM: sequences one or two word
// reads, then aligns and extends the result. MISALIGNED_SPLIT_EN enables misaligned loads.
module dmem_load_unit_rv32i
  import rv32i_mem_pkg::*;
#(
  parameter int unsigned DMEM_AW     = 8,
  parameter bit          RANGE_CHECK = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ld_req,
  input  logic [2:0]         ld_type,
  input  logic [31:0]        ld_addr,
  output logic               ld_busy,
  output logic               ld_valid,
  output logic [31:0]        ld_data,
  output logic               ld_fault,
  output logic               mem_re,
  output logic [DMEM_AW-1:0] mem_addr,
  input  logic [31:0]        mem_rdata
);

  ld_state_e          state_q, state_d;
  logic [2:0]         type_q, type_d;
  logic [1:0]         offset_q, offset_d;
  logic               fault_q, fault_d;
  logic               split_q, split_d;
  logic [31:0]        lo_q, lo_d, hi_q, hi_d;
  logic               busy_q, valid_q, valid_d, fault_out_q, fault_out_d, re_q, re_d;
  logic [31:0]        data_q, data_d;
  logic [DMEM_AW-1:0] maddr_q, maddr_d;

  logic [2:0]         req_size;
  logic [DMEM_AW-1:0] req_word;
  logic               req_split, req_misaligned, req_out_of_range, req_fault;
  logic [31:0]        extracted;

  always_comb begin
    req_size         = access_size(ld_type);
    req_word         = ld_addr[DMEM_AW+1:2];
    req_out_of_range = RANGE_CHECK && ((ld_addr >> (DMEM_AW + 2)) != 32'd0);
`ifdef MISALIGNED_SPLIT_EN
    req_split        = (4'(ld_addr[1:0]) + 4'(req_size)) > 4'd4;
    req_misaligned   = 1'b0;
`else
    req_split        = 1'b0;
    req_misaligned   = ((req_size == 3'd2) && ld_addr[0]) ||
                       ((req_size == 3'd4) && (ld_addr[1:0] != 2'b00));
`endif
    // With range checking a split at the top word would read past the RAM; without it, wrap.
    req_fault = (req_size == 3'd0) || req_out_of_range || req_misaligned ||
                (RANGE_CHECK && req_split && (&req_word));
  end

  load_extract_rv32i u_extract (
    .word_hi (hi_q),
    .word_lo (lo_q),
    .offset  (offset_q),
    .funct3  (type_q),
    .result  (extracted)
  );

  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    offset_d    = offset_q;
    fault_d     = fault_q;
    split_d     = split_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    re_d        = 1'b0;
    maddr_d     = maddr_q;
    valid_d     = 1'b0;
    fault_out_d = 1'b0;
    data_d      = data_q;
    unique case (state_q)
      StIdle: begin
        if (ld_req) begin
          type_d   = ld_type;
          offset_d = ld_addr[1:0];
          split_d  = req_split;
          fault_d  = req_fault;
          if (req_fault) begin
            state_d = StDone;
          end else begin
            state_d = StReq0;
            re_d    = 1'b1;
            maddr_d = req_word;
          end
        end
      end
      StReq0:  state_d = StWait0;
      StWait0: begin
        lo_d = mem_rdata;
        if (split_q) begin
          state_d = StReq1;
          re_d    = 1'b1;
          maddr_d = maddr_q + DMEM_AW'(1);
        end else begin
          state_d = StDone;
        end
      end
      StReq1:  state_d = StWait1;
      StWait1: begin
        hi_d    = mem_rdata;
        state_d = StDone;
      end
      StDone: begin
        valid_d     = 1'b1;
        fault_out_d = fault_q;
        data_d      = fault_q ? 32'h0 : extracted;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      type_q      <= '0;
      offset_q    <= '0;
      fault_q     <= 1'b0;
      split_q     <= 1'b0;
      lo_q        <= '0;
      hi_q        <= '0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      fault_out_q <= 1'b0;
      re_q        <= 1'b0;
      data_q      <= '0;
      maddr_q     <= '0;
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      offset_q    <= offset_d;
      fault_q     <= fault_d;
      split_q     <= split_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      busy_q      <= (state_d != StIdle);
      valid_q     <= valid_d;
      fault_out_q <= fault_out_d;
      re_q        <= re_d;
      data_q      <= data_d;
      maddr_q     <= maddr_d;
    end
  end

  assign ld_busy  = busy_q;
  assign ld_valid = valid_q;
  assign ld_data  = data_q;
  assign ld_fault = fault_out_q;
  assign mem_re   = re_q;
  assign mem_addr = maddr_q;

endmodule

// File: tb/tb_dmem_load_unit_rv32i.sv
// Directed bench for dmem_load_unit_rv32i: range-checked and wrapping instances,
// each behind a synchronous-read RAM model.
module tb_dmem_load_unit_rv32i;

  localparam logic [2:0] TLb = 3'b000, TLh = 3'b001, TLw = 3'b010;
  localparam logic [2:0] TLbu = 3'b100, TLhu = 3'b101;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [2:0]  ld_type = '0;
  logic [31:0] ld_addr = '0;

  logic        busy0, valid0, fault0, re0, busy1, valid1, fault1, re1;
  logic [31:0] data0, data1, rdata0, rdata1;
  logic [7:0]  maddr0, maddr1;

  logic [31:0] ram [256];

  int checks = 0;
  int errors = 0;

  bit          sel = 1'b0;
  int          re_n = 0;
  logic [7:0]  re_a [4];

  always #5 clock = ~clock;

  dmem_load_unit_rv32i #(.DMEM_AW(8), .RANGE_CHECK(1'b1)) dut (
    .clock(clock), .reset(reset), .ld_req(req0), .ld_type(ld_type), .ld_addr(ld_addr),
    .ld_busy(busy0), .ld_valid(valid0), .ld_data(data0), .ld_fault(fault0),
    .mem_re(re0), .mem_addr(maddr0), .mem_rdata(rdata0)
  );

  dmem_load_unit_rv32i #(.DMEM_AW(8), .RANGE_CHECK(1'b0)) dut_wrap (
    .clock(clock), .reset(reset), .ld_req(req1), .ld_type(ld_type), .ld_addr(ld_addr),
    .ld_busy(busy1), .ld_valid(valid1), .ld_data(data1), .ld_fault(fault1),
    .mem_re(re1), .mem_addr(maddr1), .mem_rdata(rdata1)
  );

  always @(posedge clock) begin
    if (re0) rdata0 <= ram[maddr0];
    if (re1) rdata1 <= ram[maddr1];
  end

  wire        cur_busy  = sel ? busy1  : busy0;
  wire        cur_valid = sel ? valid1 : valid0;
  wire        cur_fault = sel ? fault1 : fault0;
  wire        cur_re    = sel ? re1    : re0;
  wire [31:0] cur_data  = sel ? data1  : data0;
  wire [7:0]  cur_maddr = sel ? maddr1 : maddr0;

  always @(negedge clock) begin
    if (cur_re) begin
      if (re_n < 4) re_a[re_n] = cur_maddr;
      re_n++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_req(input bit on);
    if (sel) req1 = on;
    else     req0 = on;
  endtask

  task automatic run_load(input bit nr, input logic [2:0] t, input logic [31:0] a,
                          input logic [31:0] exp_data, input bit exp_fault, input int exp_lat,
                          input int exp_reads, input logic [7:0] exp_a0,
                          input logic [7:0] exp_a1, input bit spam, input string tag);
    int lat;
    int extra;
    bit seen;
    @(negedge clock);
    sel = nr;
    re_n = 0;
    ld_type = t;
    ld_addr = a;
    set_req(1'b1);
    @(posedge clock);
    #1;
    set_req(1'b0);
    // Inputs only need to hold in the acceptance cycle.
    ld_type = 3'b111;
    ld_addr = 32'hDEAD_BEEF;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      if (spam && cur_busy) begin
        ld_type = TLb;
        ld_addr = 32'h10;
        set_req(1'b1);
      end else begin
        set_req(1'b0);
      end
      @(posedge clock);
      #1;
      lat++;
      if (cur_valid) seen = 1'b1;
    end
    set_req(1'b0);
    check_eq({tag, "/valid"}, 32'(seen), 32'd1);
    check_eq({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "/data"}, cur_data, exp_data);
    check_eq({tag, "/fault"}, 32'(cur_fault), 32'(exp_fault));
    check_eq({tag, "/busy"}, 32'(cur_busy), 32'd0);
    check_eq({tag, "/reads"}, 32'(re_n), 32'(exp_reads));
    if (exp_reads > 0) check_eq({tag, "/addr0"}, 32'(re_a[0]), 32'(exp_a0));
    if (exp_reads > 1) check_eq({tag, "/addr1"}, 32'(re_a[1]), 32'(exp_a1));
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock);
      #1;
      if (cur_valid) extra++;
    end
    check_eq({tag, "/single_pulse"}, 32'(extra), 32'd0);
  endtask

  initial begin
    int stray;
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    ram[4]   = 32'h8899_AABB;
    ram[5]   = 32'h1122_3344;
    ram[0]   = 32'h7654_3210;
    ram[255] = 32'hFEDC_BA98;

    repeat (2) @(posedge clock);
    #1;
    check_eq("rst/busy",  32'(busy0),  32'd0);
    check_eq("rst/valid", 32'(valid0), 32'd0);
    check_eq("rst/fault", 32'(fault0), 32'd0);
    check_eq("rst/re",    32'(re0),    32'd0);
    check_eq("rst/data",  data0,       32'd0);
    check_eq("rst/maddr", 32'(maddr0), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    run_load(0, TLw,  32'h10, 32'h8899_AABB, 0, 3, 1, 8'd4, 8'd0, 0, "lw_10");
    run_load(0, TLb,  32'h13, 32'hFFFF_FF88, 0, 3, 1, 8'd4, 8'd0, 0, "lb_13");
    run_load(0, TLbu, 32'h13, 32'h0000_0088, 0, 3, 1, 8'd4, 8'd0, 0, "lbu_13");
    run_load(0, TLh,  32'h12, 32'hFFFF_8899, 0, 3, 1, 8'd4, 8'd0, 0, "lh_12");
    run_load(0, TLhu, 32'h10, 32'h0000_AABB, 0, 3, 1, 8'd4, 8'd0, 0, "lhu_10");
    run_load(0, 3'b011, 32'h10, 32'h0, 1, 1, 0, 8'd0, 8'd0, 0, "type_011");
    run_load(0, 3'b110, 32'h10, 32'h0, 1, 1, 0, 8'd0, 8'd0, 0, "type_110");
    run_load(0, TLw,  32'h400, 32'h0, 1, 1, 0, 8'd0, 8'd0, 0, "lw_400_range");
    run_load(0, TLw,  32'h3FE, 32'h0, 1, 1, 0, 8'd0, 8'd0, 0, "lw_3fe_range");
    run_load(1, TLw,  32'h410, 32'h8899_AABB, 0, 3, 1, 8'd4, 8'd0, 0, "wrap_lw_410");
    run_load(1, TLb,  32'h3FF, 32'hFFFF_FFFE, 0, 3, 1, 8'd255, 8'd0, 0, "wrap_lb_3ff");
`ifdef MISALIGNED_SPLIT_EN
    run_load(0, TLw, 32'h12, 32'h3344_8899, 0, 5, 2, 8'd4, 8'd5, 0, "lw_12_split");
    run_load(0, TLh, 32'h13, 32'h0000_4488, 0, 5, 2, 8'd4, 8'd5, 0, "lh_13_split");
    run_load(0, TLh, 32'h11, 32'hFFFF_99AA, 0, 3, 1, 8'd4, 8'd0, 0, "lh_11_single");
    run_load(1, TLw, 32'h3FE, 32'h3210_FEDC, 0, 5, 2, 8'd255, 8'd0, 0, "wrap_lw_3fe");
`else
    run_load(0, TLw, 32'h12, 32'h0, 1, 1, 0, 8'd0, 8'd0, 0, "lw_12_misal");
    run_load(0, TLh, 32'h13, 32'h0, 1, 1, 0, 8'd0, 8'd0, 0, "lh_13_misal");
    run_load(0, TLh, 32'h11, 32'h0, 1, 1, 0, 8'd0, 8'd0, 0, "lh_11_misal");
    run_load(1, TLw, 32'h3FE, 32'h0, 1, 1, 0, 8'd0, 8'd0, 0, "wrap_lw_3fe_misal");
`endif

    // Reset while the first read is outstanding.
    @(negedge clock);
    sel = 1'b0;
    ld_type = TLw;
    ld_addr = 32'h10;
    req0 = 1'b1;
    @(posedge clock);
    #1;
    req0 = 1'b0;
    @(posedge clock);
    #1;
    check_eq("midrst/busy_before", 32'(busy0), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("midrst/busy",  32'(busy0),  32'd0);
    check_eq("midrst/valid", 32'(valid0), 32'd0);
    check_eq("midrst/fault", 32'(fault0), 32'd0);
    check_eq("midrst/re",    32'(re0),    32'd0);
    check_eq("midrst/data",  data0,       32'd0);
    check_eq("midrst/maddr", 32'(maddr0), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock);
      #1;
      if (valid0) stray++;
    end
    check_eq("midrst/no_valid", 32'(stray), 32'd0);

    run_load(0, TLw, 32'h14, 32'h1122_3344, 0, 3, 1, 8'd5, 8'd0, 1, "lw_14_busy_req");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
